// File: rtl/execute_flag_writeback_scheduler_if.sv
// Issue, execute-unit result and flag-commit signals of execute_flag_writeback_scheduler.
// master drives issue/results/control; slave is the scheduler.
interface execute_flag_writeback_scheduler_if #(
  parameter int unsigned PTR_W = 2
);
  logic             iRESET_SYNC;
  logic             iCTRL_HOLD;
  logic             iISSUE_VALID;
  logic             iISSUE_FLAG_WRITE;
  logic [1:0]       iISSUE_UNIT;
  logic             oISSUE_BUSY;
  logic             iADDER_VALID;
  logic [4:0]       iADDER_FLAG;
  logic             iLOGIC_VALID;
  logic [4:0]       iLOGIC_FLAG;
  logic             iSHIFT_VALID;
  logic [4:0]       iSHIFT_FLAG;
  logic             iMUL_VALID;
  logic [4:0]       iMUL_FLAG;
  logic [3:0]       oUNIT_BUSY;
  logic             oFLAG_WE;
  logic [4:0]       oFLAG;
  logic             oFLAG_PENDING;
  logic [PTR_W:0]   oPENDING_COUNT;

  modport master (
    output iRESET_SYNC, iCTRL_HOLD,
    output iISSUE_VALID, iISSUE_FLAG_WRITE, iISSUE_UNIT,
    output iADDER_VALID, iADDER_FLAG, iLOGIC_VALID, iLOGIC_FLAG,
    output iSHIFT_VALID, iSHIFT_FLAG, iMUL_VALID, iMUL_FLAG,
    input  oISSUE_BUSY, oUNIT_BUSY, oFLAG_WE, oFLAG, oFLAG_PENDING, oPENDING_COUNT
  );

  modport slave (
    input  iRESET_SYNC, iCTRL_HOLD,
    input  iISSUE_VALID, iISSUE_FLAG_WRITE, iISSUE_UNIT,
    input  iADDER_VALID, iADDER_FLAG, iLOGIC_VALID, iLOGIC_FLAG,
    input  iSHIFT_VALID, iSHIFT_FLAG, iMUL_VALID, iMUL_FLAG,
    output oISSUE_BUSY, oUNIT_BUSY, oFLAG_WE, oFLAG, oFLAG_PENDING, oPENDING_COUNT
  );
endinterface

// File: rtl/execute_flag_writeback_scheduler.sv
// In-order flag commit for adder/logic/shift/mul results via an issue-order FIFO and per-unit skids.
// Optional EXECUTE_FLAG_SCHED_BYPASS_EN: a head result arriving into an empty skid commits directly.
module execute_flag_writeback_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic iCLOCK,
  input logic inRESET,
  execute_flag_writeback_scheduler_if.slave bus
);
  localparam int unsigned UNITS = 4;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COMMIT,
    HELD
  } ctrlState_t;

  logic [1:0]       orderFifo [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic [UNITS-1:0] skidValid;
  logic [4:0]       skidFlag [UNITS];
  logic             flagWe;
  logic [4:0]       flag;

  logic [UNITS-1:0] unitValid;
  logic [4:0]       unitFlag [UNITS];
  logic [1:0]       headUnit;
  logic             fifoFull;
  logic             pushEn;
  logic             bypassHit;
  logic             headReady;
  ctrlState_t       ctrlState;
  logic             commitEn;
  logic             useBypass;
  logic [4:0]       commitFlag;
  logic [UNITS-1:0] captureEn;

  assign unitValid = {bus.iMUL_VALID, bus.iSHIFT_VALID, bus.iLOGIC_VALID, bus.iADDER_VALID};

  always_comb begin
    unitFlag[0] = bus.iADDER_FLAG;
    unitFlag[1] = bus.iLOGIC_FLAG;
    unitFlag[2] = bus.iSHIFT_FLAG;
    unitFlag[3] = bus.iMUL_FLAG;
  end

  assign headUnit = orderFifo[rdPtr];
  assign fifoFull = (count == FULL_COUNT);
  assign pushEn   = bus.iISSUE_VALID & bus.iISSUE_FLAG_WRITE & !fifoFull & !bus.iCTRL_HOLD;

`ifdef EXECUTE_FLAG_SCHED_BYPASS_EN
  assign bypassHit = unitValid[headUnit] & !skidValid[headUnit];
`else
  assign bypassHit = 1'b0;
`endif

  assign headReady = skidValid[headUnit] | bypassHit;

  // Control state is a pure decode of the registered count, hold and head readiness.
  always_comb begin
    ctrlState  = IDLE;
    commitEn   = 1'b0;
    useBypass  = 1'b0;
    commitFlag = skidFlag[headUnit];
    if (count != '0) begin
      if (bus.iCTRL_HOLD) begin
        ctrlState = HELD;
      end else if (headReady) begin
        ctrlState = COMMIT;
      end else begin
        ctrlState = WAIT;
      end
    end
    if (ctrlState == COMMIT) begin
      commitEn  = 1'b1;
      useBypass = !skidValid[headUnit];
      if (useBypass) begin
        commitFlag = unitFlag[headUnit];
      end
    end
  end

  // A bypassed head result never lands in its skid; busy skids drop protocol-violating results.
  always_comb begin
    captureEn = '0;
    for (int unsigned u = 0; u < UNITS; u++) begin
      captureEn[u] = unitValid[u] & !skidValid[u] & !(useBypass && (headUnit == 2'(u)));
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      skidValid <= '0;
      flagWe    <= 1'b0;
      flag      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        orderFifo[i] <= '0;
      end
      for (int unsigned u = 0; u < UNITS; u++) begin
        skidFlag[u] <= '0;
      end
    end else if (bus.iRESET_SYNC) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      skidValid <= '0;
      flagWe    <= 1'b0;
    end else begin
      if (pushEn) begin
        orderFifo[wrPtr] <= bus.iISSUE_UNIT;
        wrPtr            <= wrPtr + PTR_W'(1);
      end
      if (commitEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({pushEn, commitEn})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      for (int unsigned u = 0; u < UNITS; u++) begin
        if (captureEn[u]) begin
          skidValid[u] <= 1'b1;
          skidFlag[u]  <= unitFlag[u];
        end else if (commitEn && (headUnit == 2'(u))) begin
          skidValid[u] <= 1'b0;
        end
      end
      flagWe <= commitEn;
      if (commitEn) begin
        flag <= commitFlag;
      end
    end
  end

  assign bus.oISSUE_BUSY    = fifoFull;
  assign bus.oUNIT_BUSY     = skidValid;
  assign bus.oFLAG_WE       = flagWe;
  assign bus.oFLAG          = flag;
  assign bus.oFLAG_PENDING  = (count != '0);
  assign bus.oPENDING_COUNT = count;
endmodule

// File: tb/tb_execute_flag_writeback_scheduler.sv
// Directed bench for execute_flag_writeback_scheduler; expectations follow EXECUTE_FLAG_SCHED_BYPASS_EN.
module tb_execute_flag_writeback_scheduler;
`ifdef EXECUTE_FLAG_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic nRst;
  int   nVec;
  int   nErr;

  execute_flag_writeback_scheduler_if #(.PTR_W(2)) bus ();

  execute_flag_writeback_scheduler #(
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .iCLOCK (clk),
    .inRESET(nRst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearIns();
    bus.iRESET_SYNC       = 1'b0;
    bus.iCTRL_HOLD        = 1'b0;
    bus.iISSUE_VALID      = 1'b0;
    bus.iISSUE_FLAG_WRITE = 1'b0;
    bus.iISSUE_UNIT       = 2'd0;
    bus.iADDER_VALID      = 1'b0;
    bus.iADDER_FLAG       = 5'h00;
    bus.iLOGIC_VALID      = 1'b0;
    bus.iLOGIC_FLAG       = 5'h00;
    bus.iSHIFT_VALID      = 1'b0;
    bus.iSHIFT_FLAG       = 5'h00;
    bus.iMUL_VALID        = 1'b0;
    bus.iMUL_FLAG         = 5'h00;
  endtask

  task automatic issue(input logic [1:0] u);
    bus.iISSUE_VALID      = 1'b1;
    bus.iISSUE_FLAG_WRITE = 1'b1;
    bus.iISSUE_UNIT       = u;
  endtask

  task automatic noIssue();
    bus.iISSUE_VALID      = 1'b0;
    bus.iISSUE_FLAG_WRITE = 1'b0;
  endtask

  initial begin
    nVec = 0;
    nErr = 0;

    // Reset with random inputs
    nRst                  = 1'b0;
    bus.iRESET_SYNC       = 1'($urandom);
    bus.iCTRL_HOLD        = 1'($urandom);
    bus.iISSUE_VALID      = 1'($urandom);
    bus.iISSUE_FLAG_WRITE = 1'($urandom);
    bus.iISSUE_UNIT       = 2'($urandom);
    bus.iADDER_VALID      = 1'($urandom);
    bus.iADDER_FLAG       = 5'($urandom);
    bus.iLOGIC_VALID      = 1'($urandom);
    bus.iLOGIC_FLAG       = 5'($urandom);
    bus.iSHIFT_VALID      = 1'($urandom);
    bus.iSHIFT_FLAG       = 5'($urandom);
    bus.iMUL_VALID        = 1'($urandom);
    bus.iMUL_FLAG         = 5'($urandom);
    tick();
    chk("rst_flag", bus.oFLAG, 5'h00);
    chk("rst_we", bus.oFLAG_WE, 1'b0);
    chk("rst_count", bus.oPENDING_COUNT, 3'd0);
    chk("rst_ibusy", bus.oISSUE_BUSY, 1'b0);
    chk("rst_ubusy", bus.oUNIT_BUSY, 4'h0);
    chk("rst_pend", bus.oFLAG_PENDING, 1'b0);
    nRst = 1'b1;
    clearIns();

    // Non-flag-writing issue is ignored
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_UNIT  = 2'd2;
    tick();
    chk("nfw_count", bus.oPENDING_COUNT, 3'd0);

    // In-order: ADDER then LOGIC
    issue(2'd0); tick();
    issue(2'd1); tick();
    noIssue();
    chk("io_count", bus.oPENDING_COUNT, 3'd2);
    chk("io_pend", bus.oFLAG_PENDING, 1'b1);
    bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h03;
    tick();
    bus.iADDER_VALID = 1'b0;
    chk("io_t1_we", bus.oFLAG_WE, BYP ? 1'b1 : 1'b0);
    chk("io_t1_flag", bus.oFLAG, BYP ? 5'h03 : 5'h00);
    chk("io_t1_ubusy", bus.oUNIT_BUSY, BYP ? 4'h0 : 4'h1);
    bus.iLOGIC_VALID = 1'b1; bus.iLOGIC_FLAG = 5'h10;
    tick();
    bus.iLOGIC_VALID = 1'b0;
    chk("io_t2_we", bus.oFLAG_WE, 1'b1);
    chk("io_t2_flag", bus.oFLAG, BYP ? 5'h10 : 5'h03);
    chk("io_t2_count", bus.oPENDING_COUNT, BYP ? 3'd0 : 3'd1);
    chk("io_t2_ubusy", bus.oUNIT_BUSY, BYP ? 4'h0 : 4'h2);
    tick();
    chk("io_t3_we", bus.oFLAG_WE, BYP ? 1'b0 : 1'b1);
    chk("io_t3_flag", bus.oFLAG, 5'h10);
    chk("io_t3_count", bus.oPENDING_COUNT, 3'd0);
    chk("io_t3_pend", bus.oFLAG_PENDING, 1'b0);

    // Out-of-order completion: MUL then ADDER, ADDER result first
    issue(2'd3); tick();
    issue(2'd0); tick();
    noIssue();
    bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h01;
    tick();
    bus.iADDER_VALID = 1'b0;
    chk("ooo_a_ubusy", bus.oUNIT_BUSY, 4'h1);
    chk("ooo_a_we", bus.oFLAG_WE, 1'b0);
    tick(); tick();
    chk("ooo_w_ubusy", bus.oUNIT_BUSY, 4'h1);
    chk("ooo_w_we", bus.oFLAG_WE, 1'b0);
    chk("ooo_w_count", bus.oPENDING_COUNT, 3'd2);
    bus.iMUL_VALID = 1'b1; bus.iMUL_FLAG = 5'h1F;
    tick();
    bus.iMUL_VALID = 1'b0;
    chk("ooo_m_we", bus.oFLAG_WE, BYP ? 1'b1 : 1'b0);
    chk("ooo_m_flag", bus.oFLAG, BYP ? 5'h1F : 5'h10);
    chk("ooo_m_ubusy", bus.oUNIT_BUSY, BYP ? 4'h1 : 4'h9);
    chk("ooo_m_count", bus.oPENDING_COUNT, BYP ? 3'd1 : 3'd2);
    tick();
    chk("ooo_c1_we", bus.oFLAG_WE, 1'b1);
    chk("ooo_c1_flag", bus.oFLAG, BYP ? 5'h01 : 5'h1F);
    chk("ooo_c1_ubusy", bus.oUNIT_BUSY, BYP ? 4'h0 : 4'h1);
    chk("ooo_c1_pend", bus.oFLAG_PENDING, BYP ? 1'b0 : 1'b1);
    tick();
    chk("ooo_c2_we", bus.oFLAG_WE, BYP ? 1'b0 : 1'b1);
    chk("ooo_c2_flag", bus.oFLAG, 5'h01);
    chk("ooo_c2_count", bus.oPENDING_COUNT, 3'd0);
    chk("ooo_c2_pend", bus.oFLAG_PENDING, 1'b0);
    chk("ooo_c2_ubusy", bus.oUNIT_BUSY, 4'h0);

    // Full FIFO
    issue(2'd2); tick(); tick(); tick();
    chk("full3_count", bus.oPENDING_COUNT, 3'd3);
    chk("full3_busy", bus.oISSUE_BUSY, 1'b0);
    tick();
    chk("full4_count", bus.oPENDING_COUNT, 3'd4);
    chk("full4_busy", bus.oISSUE_BUSY, 1'b1);
    chk("full4_pend", bus.oFLAG_PENDING, 1'b1);
    issue(2'd1); tick();
    chk("full5_count", bus.oPENDING_COUNT, 3'd4);
    chk("full5_busy", bus.oISSUE_BUSY, 1'b1);
    issue(2'd0);
    bus.iSHIFT_VALID = 1'b1; bus.iSHIFT_FLAG = 5'h07;
    tick();
    bus.iSHIFT_VALID = 1'b0;
    chk("fullc1_count", bus.oPENDING_COUNT, BYP ? 3'd3 : 3'd4);
    chk("fullc1_we", bus.oFLAG_WE, BYP ? 1'b1 : 1'b0);
    chk("fullc1_ubusy", bus.oUNIT_BUSY, BYP ? 4'h0 : 4'h4);
    tick();
    chk("fullc2_count", bus.oPENDING_COUNT, BYP ? 3'd4 : 3'd3);
    chk("fullc2_we", bus.oFLAG_WE, BYP ? 1'b0 : 1'b1);
    chk("fullc2_flag", bus.oFLAG, 5'h07);
    noIssue();
    bus.iRESET_SYNC = 1'b1; tick(); bus.iRESET_SYNC = 1'b0;
    chk("fullf_count", bus.oPENDING_COUNT, 3'd0);
    chk("fullf_busy", bus.oISSUE_BUSY, 1'b0);

    // Hold: capture proceeds, push and commit frozen
    issue(2'd0); tick(); noIssue();
    chk("hold0_count", bus.oPENDING_COUNT, 3'd1);
    bus.iCTRL_HOLD = 1'b1;
    bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = 5'h0A;
    issue(2'd1);
    tick();
    bus.iADDER_VALID = 1'b0; noIssue();
    chk("hold1_we", bus.oFLAG_WE, 1'b0);
    chk("hold1_count", bus.oPENDING_COUNT, 3'd1);
    chk("hold1_ubusy", bus.oUNIT_BUSY, 4'h1);
    tick();
    chk("hold2_we", bus.oFLAG_WE, 1'b0);
    chk("hold2_count", bus.oPENDING_COUNT, 3'd1);
    chk("hold2_flag", bus.oFLAG, 5'h07);
    bus.iCTRL_HOLD = 1'b0;
    issue(2'd1); tick(); noIssue();
    chk("hold3_we", bus.oFLAG_WE, 1'b1);
    chk("hold3_flag", bus.oFLAG, 5'h0A);
    chk("hold3_count", bus.oPENDING_COUNT, 3'd1);
    chk("hold3_ubusy", bus.oUNIT_BUSY, 4'h0);

    // Flush with two pending entries and one captured skid
    issue(2'd2); tick(); noIssue();
    chk("fl0_count", bus.oPENDING_COUNT, 3'd2);
    chk("fl0_we", bus.oFLAG_WE, 1'b0);
    bus.iSHIFT_VALID = 1'b1; bus.iSHIFT_FLAG = 5'h15;
    tick();
    bus.iSHIFT_VALID = 1'b0;
    chk("fl1_ubusy", bus.oUNIT_BUSY, 4'h4);
    chk("fl1_count", bus.oPENDING_COUNT, 3'd2);
    bus.iRESET_SYNC = 1'b1;
    bus.iLOGIC_VALID = 1'b1; bus.iLOGIC_FLAG = 5'h11;
    issue(2'd0);
    tick();
    clearIns();
    chk("fl2_count", bus.oPENDING_COUNT, 3'd0);
    chk("fl2_ubusy", bus.oUNIT_BUSY, 4'h0);
    chk("fl2_flag", bus.oFLAG, 5'h0A);
    chk("fl2_we", bus.oFLAG_WE, 1'b0);
    chk("fl2_pend", bus.oFLAG_PENDING, 1'b0);
    tick();
    chk("fl3_ubusy", bus.oUNIT_BUSY, 4'h0);
    chk("fl3_count", bus.oPENDING_COUNT, 3'd0);

    // Result before its issue waits in skid; a result while busy is dropped
    bus.iMUL_VALID = 1'b1; bus.iMUL_FLAG = 5'h02;
    tick();
    bus.iMUL_VALID = 1'b0;
    chk("orph0_ubusy", bus.oUNIT_BUSY, 4'h8);
    chk("orph0_we", bus.oFLAG_WE, 1'b0);
    issue(2'd3);
    bus.iMUL_VALID = 1'b1; bus.iMUL_FLAG = 5'h1F;
    tick();
    bus.iMUL_VALID = 1'b0; noIssue();
    chk("orph1_count", bus.oPENDING_COUNT, 3'd1);
    chk("orph1_we", bus.oFLAG_WE, 1'b0);
    chk("orph1_ubusy", bus.oUNIT_BUSY, 4'h8);
    tick();
    chk("orph2_we", bus.oFLAG_WE, 1'b1);
    chk("orph2_flag", bus.oFLAG, 5'h02);
    chk("orph2_count", bus.oPENDING_COUNT, 3'd0);
    chk("orph2_ubusy", bus.oUNIT_BUSY, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
